serial_logic_unit_n: RTL
========================

Name: serial_logic_unit_n

Overview:
- Parametrised bit-serial logic unit: processes one bit per clock, LSB first, and computes a bitwise AND, OR, XOR or alternating AND/OR of two WIDTH-bit operands.
- Generalises the fixed 4-bit serial AND/OR datapath in three ways: configurable width, runtime operation mode, and runtime operand length.
- Start/busy/done handshake toward the controlling FSM; state is exported for lab observation.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1), width of the length and bit-index fields; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- s  in  1  start request; sampled only in IDLE.
- mode  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 alternating (even bit AND, odd bit OR); captured at start.
- len  in  CW  number of bits to process; 0 or >WIDTH means WIDTH; captured at start.
- Ain  in  WIDTH  operand A; captured at start.
- Bin  in  WIDTH  operand B; captured at start.
- C  out  WIDTH  result register; bits [len-1:0] valid, upper bits 0.
- busy  out  1  high while in PROC or DONE.
- done  out  1  one-cycle pulse: result valid.
- curstate  out  2  IDLE=00, PROC=01, DONE=10.

Behaviour:
- Fully synchronous; all outputs are registered. No combinational path from inputs to outputs.
- Reset (reset==0 at a clk edge), including mid-operation: curstate=IDLE, C=0, busy=0, done=0, internal A/B/idx/mode/len cleared. Any in-flight operation is abandoned.
- IDLE:
  - On an edge with s==1: A<=Ain, B<=Bin, mode and len latched (len normalised), idx<=0, C<=0, busy<=1, go to PROC.
  - Otherwise hold; C keeps the previous result.
- PROC, each edge:
  - C[idx] <= f(A[0],B[0],mode,idx); f for mode 11 is AND when idx is even, OR when idx is odd.
  - A<=A>>1, B<=B>>1, idx<=idx+1.
  - When idx==len-1 on this edge, go to DONE with done<=1.
- DONE: lasts one cycle; done<=0, busy<=0 on exit, return to IDLE. C is held.
- Latency: with start sampled at edge 0, done is high in the cycle after edge len (len PROC cycles), and a new start is accepted at edge len+2 at the earliest.
- s is ignored in PROC and DONE; it is not queued. Ain, Bin, mode and len may change freely after capture without affecting the result.
- len=1: a single PROC cycle; C[0] only.
- len=WIDTH: the idx counter stops at WIDTH-1 and never wraps into a write outside C.
- Bits of C above len-1 stay 0; C was cleared at start.

Test Plan (WIDTH=8):
- Reset low for 2 cycles, then release -> C=0x00, busy=0, done=0, curstate=00; s held at 0 for 5 cycles -> no state change.
- mode=11, len=0, Ain=0xB5, Bin=0x6C, pulse s -> busy for 9 cycles, done pulses once in the 9th, C=0xAC.
- mode=10, len=8, Ain=0xB5, Bin=0x6C -> C=0xD9; mode=01 with the same operands -> C=0xFD.
- mode=00, len=4, Ain=0xB5, Bin=0x6C -> done after 4 PROC cycles, C=0x04 (upper nibble 0); len=1, mode=01, Ain=0x00, Bin=0x01 -> C=0x01.
- Start an operation, then assert s and change Ain/Bin/mode during PROC -> result unaffected and no second run; start a new run immediately after DONE -> accepted, with correct back-to-back results.
- Drive reset low during the 3rd PROC cycle -> next edge curstate=00, C=0, busy=0, done never pulses; a subsequent start completes normally.

Source files
------------

// File: rtl/serial_logic_unit_n.sv
// serial_logic_unit_n: bit-serial logic unit, one result bit per clock, LSB first.
// Computes AND / OR / XOR / alternating AND-OR (even bits AND, odd bits OR) of
// two WIDTH-bit operands over a runtime-selected number of bits.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-low reset
//   s        in   start request, sampled only in IDLE
//   mode     in   00 AND, 01 OR, 10 XOR, 11 alternating; captured at start
//   len      in   bits to process; 0 or >WIDTH means WIDTH; captured at start
//   Ain/Bin  in   operands, captured at start
//   C        out  result; bits above len-1 are 0
//   busy     out  high in PROC and DONE
//   done     out  one-cycle pulse when C is valid
//   curstate out  IDLE=00, PROC=01, DONE=10
module serial_logic_unit_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [1:0]       mode,
    input  logic [CW-1:0]    len,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic [WIDTH-1:0] C,
    output logic             busy,
    output logic             done,
    output logic [1:0]       curstate
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StProc = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [1:0]       mode_q, mode_d;
    logic [CW-1:0]    len_q, len_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_res;
    logic             last;

    assign last = (idx_q == len_q - CW'(1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        mode_d  = mode_q;
        len_d   = len_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bit_res = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (s) begin
                    a_d     = Ain;
                    b_d     = Bin;
                    mode_d  = mode;
                    // Out-of-range lengths fall back to a full-width operation.
                    len_d   = (len == '0 || len > CW'(WIDTH)) ? CW'(WIDTH) : len;
                    idx_d   = '0;
                    c_d     = '0;
                    busy_d  = 1'b1;
                    state_d = StProc;
                end
            end
            StProc: begin
                case (mode_q)
                    2'b00:   bit_res = a_q[0] & b_q[0];
                    2'b01:   bit_res = a_q[0] | b_q[0];
                    2'b10:   bit_res = a_q[0] ^ b_q[0];
                    default: bit_res = idx_q[0] ? (a_q[0] | b_q[0]) : (a_q[0] & b_q[0]);
                endcase
                c_d = c_q | (WIDTH'(bit_res) << idx_q);
                a_d = a_q >> 1;
                b_d = b_q >> 1;
                if (last) begin
                    // idx freezes on the final bit so it never reaches WIDTH.
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            mode_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign C        = c_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign curstate = state_q;

endmodule
